// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared state encoding and default timing constants for prime_req
package prime_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        REQ       = 4'b0010,
        WAIT_BUSY = 4'b0100,
        WAIT_DONE = 4'b1000
    } state_t;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 31;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - push-button synchronizer, debounce filter and rising-edge pulse
module btn_edge
    import prime_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // A new level is accepted only after DEB_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= btn;
            sync    <= meta;
            level_q <= level;
            if (sync != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/prime_req.sv
// rtl/prime_req.sv - button-driven candidate counter issuing requests to an external prime checker
module prime_req
    import prime_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       start_i,
    input  logic       valid_i,
    input  logic       prime_i,
    output logic       en_o,
    output logic [3:0] data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       result_o,
    output logic       err_o
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t         state, state_nx;
    logic [3:0]     data_nx;
    logic           done_nx, result_nx, err_nx;
    logic [WDW-1:0] wdog, wdog_nx;
    logic           inc_p, dec_p, start_p;

    btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_inc   (.clk(clk), .rst_n(rst_n), .btn(inc_i),   .pulse(inc_p));
    btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_dec   (.clk(clk), .rst_n(rst_n), .btn(dec_i),   .pulse(dec_p));
    btn_edge #(.DEB_CYCLES(DEB_CYCLES)) u_start (.clk(clk), .rst_n(rst_n), .btn(start_i), .pulse(start_p));

    always_comb begin
        state_nx  = state;
        data_nx   = data_o;
        done_nx   = 1'b0;
        result_nx = result_o;
        err_nx    = err_o;
        wdog_nx   = wdog;
        unique case (state)
            IDLE: begin
                // A start pulse wins over a coincident inc/dec so the checked value is the one shown.
                if (start_p) begin
                    if (data_o >= 4'd2) begin
                        state_nx = REQ;
                    end else begin
                        done_nx   = 1'b1;
                        result_nx = 1'b0;
                        err_nx    = 1'b0;
                    end
                end else if (inc_p && !dec_p) begin
                    data_nx = data_o + 4'd1;
                end else if (dec_p && !inc_p) begin
                    data_nx = data_o - 4'd1;
                end
            end
            REQ: begin
                state_nx = WAIT_BUSY;
                wdog_nx  = '0;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (state == WAIT_DONE && valid_i) begin
                    state_nx  = IDLE;
                    result_nx = prime_i;
                    err_nx    = 1'b0;
                    done_nx   = 1'b1;
                end else if (wdog == WD_LAST) begin
                    state_nx  = IDLE;
                    result_nx = 1'b0;
                    err_nx    = 1'b1;
                    done_nx   = 1'b1;
                end else begin
                    wdog_nx = wdog + WDW'(1);
                    if (state == WAIT_BUSY && !valid_i) begin
                        state_nx = WAIT_DONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // en_o and busy_o are registered from the next state so they line up exactly with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_o   <= 4'd2;
            en_o     <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= 1'b0;
            err_o    <= 1'b0;
            wdog     <= '0;
        end else begin
            state    <= state_nx;
            data_o   <= data_nx;
            en_o     <= (state_nx == REQ);
            busy_o   <= (state_nx != IDLE);
            done_o   <= done_nx;
            result_o <= result_nx;
            err_o    <= err_nx;
            wdog     <= wdog_nx;
        end
    end

endmodule

// File: tb/tb_prime_req.sv
// tb/tb_prime_req.sv - scoreboard bench for prime_req with a behavioural checker model
module tb_prime_req;

    localparam int TMO = 31;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc_i, dec_i, start_i, valid_i, prime_i;
    logic       en_o, busy_o, done_o, result_o, err_o;
    logic [3:0] data_o;

    always #5 clk = ~clk;

    prime_req #(.DEB_CYCLES(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_i), .dec_i(dec_i), .start_i(start_i),
        .valid_i(valid_i), .prime_i(prime_i), .en_o(en_o), .data_o(data_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .err_o(err_o)
    );

    int         nchecks = 0;
    int         nerr    = 0;
    logic [1:0] exp_q[$];
    int         done_cnt = 0, en_cnt = 0, cyc = 0, en_cyc = 0;
    int         drop_d = 2, raise_d = 6;
    bit         hang = 1'b0;
    bit         en_prev = 1'b0, done_prev = 1'b0;
    logic [3:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++)
            if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    // monitor / scoreboard
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (en_o) begin
                    en_cnt++;
                    en_cyc = cyc;
                    check("en_one_cycle", en_prev, 0);
                    check("busy_in_req", busy_o, 1);
                end
                if (done_o) begin
                    done_cnt++;
                    check("done_one_cycle", done_prev, 0);
                    if (exp_q.size() == 0) begin
                        nchecks++;
                        nerr++;
                        $display("FAIL unexpected_done: got done_o=1 expected no pending request");
                    end else begin
                        e = exp_q.pop_front();
                        check("result", result_o, e[1]);
                        check("err", err_o, e[0]);
                        check("busy_after_done", busy_o, 0);
                        if (e[0]) check("timeout_latency", cyc - en_cyc, TMO + 1);
                    end
                end
            end
            en_prev   = en_o;
            done_prev = done_o;
        end
    end

    // external checker model
    initial begin
        logic [3:0] cap;
        valid_i = 1'b1;
        prime_i = 1'b0;
        forever begin
            @(negedge clk);
            if (en_o && rst_n) begin
                cap = data_o;
                repeat (drop_d) @(negedge clk);
                if (!hang) begin
                    valid_i = 1'b0;
                    repeat (raise_d) @(negedge clk);
                    prime_i = is_prime(int'(cap));
                    valid_i = 1'b1;
                    @(negedge clk);
                    prime_i = 1'b0;
                end
            end
        end
    end

    task automatic press(input bit i, input bit d, input bit s);
        @(negedge clk);
        inc_i = i; dec_i = d; start_i = s;
        repeat (8) @(negedge clk);
        inc_i = 1'b0; dec_i = 1'b0; start_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic step(input bit up);
        press(up, !up, 1'b0);
        exp_data = up ? exp_data + 4'd1 : exp_data - 4'd1;
    endtask

    task automatic goto(input logic [3:0] t);
        logic [3:0] diff;
        if ($urandom_range(0, 1) == 1) begin
            diff = t - exp_data;
            repeat (int'(diff)) step(1'b1);
        end else begin
            diff = exp_data - t;
            repeat (int'(diff)) step(1'b0);
        end
        check("data_nav", data_o, exp_data);
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk);
    endtask

    task automatic run_check(input logic [3:0] v);
        int d0, e0;
        goto(v);
        hang = 1'b0;
        exp_q.push_back({(v >= 2) ? is_prime(int'(v)) : 1'b0, 1'b0});
        d0 = done_cnt;
        e0 = en_cnt;
        press(1'b0, 1'b0, 1'b1);
        if (v < 2) check("short_done_prompt", done_cnt - d0, 1);
        wait_done(d0, 60);
        check("done_seen", done_cnt - d0, 1);
        check("en_count", en_cnt - e0, (v >= 2) ? 1 : 0);
        check("data_held", data_o, exp_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int d0, e0;
        rst_n = 1'b0;
        inc_i = 1'b0; dec_i = 1'b0; start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", data_o, 2);
        check("rst_en", en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result", result_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;
        exp_data = 4'd2;

        drop_d = 2; raise_d = 6;
        run_check(4'd7);
        run_check(4'd9);
        run_check(4'd1);

        goto(4'd15);
        step(1'b1);
        check("wrap_inc", data_o, 0);
        step(1'b0);
        check("wrap_dec", data_o, 15);
        press(1'b1, 1'b1, 1'b0);
        check("inc_dec_same", data_o, 15);

        for (int it = 0; it < 10; it++) begin
            drop_d  = $urandom_range(1, 3);
            raise_d = $urandom_range(1, 15);
            run_check(4'($urandom_range(0, 15)));
        end

        // checker never drops valid: watchdog abort, presses while busy ignored
        goto(4'd11);
        drop_d = 2;
        hang = 1'b1;
        exp_q.push_back(2'b01);
        d0 = done_cnt;
        e0 = en_cnt;
        press(1'b0, 1'b0, 1'b1);
        check("busy_during_wait", busy_o, 1);
        press(1'b1, 1'b0, 1'b1);
        wait_done(d0, 60);
        check("timeout_done", done_cnt - d0, 1);
        hang = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_press_data", data_o, exp_data);
        check("busy_press_no_req", en_cnt - e0, 1);

        // bouncing inc button
        repeat (4) begin
            @(negedge clk);
            inc_i = 1'b1;
            repeat (3) @(negedge clk);
            inc_i = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("bounce_no_inc", data_o, exp_data);

        // reset while in WAIT_DONE
        goto(4'd13);
        drop_d = 2; raise_d = 20;
        exp_q.push_back({1'b1, 1'b0});
        d0 = done_cnt;
        press(1'b0, 1'b0, 1'b1);
        check("mid_busy", busy_o, 1);
        check("mid_valid_low", valid_i, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", data_o, 2);
        check("mid_rst_en", en_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_result", result_o, 0);
        check("mid_rst_err", err_o, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_data = 4'd2;
        repeat (30) @(negedge clk);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_data", data_o, 2);
        check("post_rst_busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/prime_req.md
PRIME_REQ -- requirements
Module: prime_req

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 4, meaning the number of consecutive stable synchronized samples before a button level is accepted.
REQ-002 The block SHALL have parameter TIMEOUT, default 31, meaning the maximum number of cycles spent waiting on the checker before aborting.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all logic is on posedge.
REQ-004 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have ports inc_i, dec_i and start_i, input, width 1 each: raw asynchronous push-buttons, active-high.
REQ-006 The block SHALL have port valid_i, input, width 1: checker ready/result-valid level; 1 = idle/done, 0 = computing.
REQ-007 The block SHALL have port prime_i, input, width 1: checker result, meaningful only on the cycle valid_i rises.
REQ-008 The block SHALL have port en_o, output, width 1: one-cycle request pulse to the checker.
REQ-009 The block SHALL have port data_o, output, width 4: candidate value, registered.
REQ-010 The block SHALL have port busy_o, output, width 1: high while a check is in progress.
REQ-011 The block SHALL have port done_o, output, width 1: one-cycle pulse when result_o/err_o are updated.
REQ-012 The block SHALL have ports result_o and err_o, output, width 1 each: latched prime verdict and latched timeout flag.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer, then a DEB_CYCLES debounce filter, then a rising-edge detector producing a one-cycle pulse.
REQ-014 In IDLE, an inc pulse SHALL make data_o = data_o+1 (15 wraps to 0), and a dec pulse SHALL make data_o = data_o-1 (0 wraps to 15); if inc and dec pulse in the same cycle, data_o SHALL be unchanged.
REQ-015 Inc and dec pulses SHALL be ignored outside IDLE, and data_o SHALL be held stable from REQ until return to IDLE.
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT_BUSY and WAIT_DONE.
REQ-017 On a start pulse in IDLE with data_o >= 2, the FSM SHALL go to REQ.
REQ-018 On a start pulse in IDLE with data_o of 0 or 1, the FSM SHALL issue no request and SHALL set, on the next cycle, result_o=0, err_o=0 and done_o=1.
REQ-019 The FSM SHALL assert en_o=1 during REQ (exactly one cycle) and then enter WAIT_BUSY.
REQ-020 In WAIT_BUSY, valid_i=0 SHALL move the FSM to WAIT_DONE.
REQ-021 In WAIT_DONE, the first cycle with valid_i=1 SHALL latch result_o=prime_i, clear err_o, pulse done_o on the next cycle and return to IDLE.
REQ-022 A watchdog counter, cleared on entry to WAIT_BUSY, SHALL abort to IDLE with err_o=1, result_o=0 and done_o pulsed once TIMEOUT cycles elapse in WAIT_BUSY/WAIT_DONE.
REQ-023 busy_o SHALL be 1 in REQ, WAIT_BUSY and WAIT_DONE, and 0 in IDLE.
REQ-024 A start pulse outside IDLE SHALL be ignored.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously force: state=IDLE, data_o=2, en_o=0, busy_o=0, done_o=0, result_o=0, err_o=0, synchronizer/debounce/edge registers=0, watchdog=0.
REQ-026 Reset asserted mid-check SHALL abort immediately with no done_o pulse after release.

Structure
REQ-027 The state enum (one-hot, 4 bits) and default DEB_CYCLES/TIMEOUT constants SHALL live in shared package prime_pkg.
REQ-028 Synchronizer, debounce and edge detect SHALL form sub-module btn_edge, instantiated three times.

Verification
REQ-029 data_o=7, start, with a checker model dropping valid_i 2 cycles after en_o and raising it with prime_i=1 after 6 cycles -> en_o one pulse, result_o=1, done_o one pulse, busy_o falls.
REQ-030 data_o=9, checker returns prime_i=0 -> result_o=0, err_o=0.
REQ-031 data_o=15, one inc -> data_o=0; one dec -> 15; inc and dec in the same cycle -> unchanged.
REQ-032 data_o=1, start -> en_o never asserted, done_o within 2 cycles, result_o=0.
REQ-033 Checker holding valid_i=1 after en_o -> err_o=1 after 31 cycles; inc/start presses while busy have no effect.
REQ-034 Button bouncing (3-cycle pulses, DEB_CYCLES=4) -> no increments; reset asserted in WAIT_DONE -> all outputs at reset values.
